// File: rtl/seg7_hex_packer.sv
// Decodes active-low 7-segment codes back to hex nibbles and packs DIGITS of
// them, MS nibble first, into a word delivered over a valid/ready handshake.
module seg7_hex_packer #(
  parameter int DIGITS     = 4,
  parameter int data_width = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         seg_valid,
  input  logic [6:0]                   seg,
  output logic                         seg_ready,
  input  logic                         flush,
  output logic [DIGITS*data_width-1:0] word,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         word_err,
  output logic [7:0]                   err_count
);

  localparam int WW = DIGITS * data_width;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  // Returns {illegal, nibble}; illegal codes decode to nibble 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] code);
    case (code)
      7'b1000000: seg_decode = 5'h00;
      7'b1111001: seg_decode = 5'h01;
      7'b0100100: seg_decode = 5'h02;
      7'b0110000: seg_decode = 5'h03;
      7'b0011001: seg_decode = 5'h04;
      7'b0010010: seg_decode = 5'h05;
      7'b0000010: seg_decode = 5'h06;
      7'b1111000: seg_decode = 5'h07;
      7'b0000000: seg_decode = 5'h08;
      7'b0010000: seg_decode = 5'h09;
      7'b0001000: seg_decode = 5'h0A;
      7'b0000011: seg_decode = 5'h0B;
      7'b1000110: seg_decode = 5'h0C;
      7'b0100001: seg_decode = 5'h0D;
      7'b0000110: seg_decode = 5'h0E;
      7'b0001110: seg_decode = 5'h0F;
      default:    seg_decode = 5'h10;
    endcase
  endfunction

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] word_q, word_d;
  logic          word_err_q, word_err_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [4:0]    dec_s;
  logic          accept_s;

  // Next-state, packing and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    word_err_d  = word_err_q;
    err_count_d = err_count_q;
    dec_s       = seg_decode(seg);
    accept_s    = seg_valid && (state_q == ST_FILL);

    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          // Unfilled nibbles are always zero in FILL, so OR-ing places the digit.
          word_d = word_q | (WW'(dec_s[3:0]) << ((DIGITS - 1 - int'(cnt_q)) * data_width));
          cnt_d  = cnt_q + CW'(1);
          if (dec_s[4]) begin
            word_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end else begin
              err_count_d = err_count_q;
            end
          end else begin
            word_err_d = word_err_q;
          end
          if ((cnt_q == CW'(DIGITS - 1)) || flush) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_FILL;
          end
        end else if (flush && (cnt_q != {CW{1'b0}})) begin
          state_d = ST_FULL;
        end else begin
          state_d = state_q;
        end
      end
      ST_FULL: begin
        if (word_ready) begin
          state_d    = ST_FILL;
          cnt_d      = {CW{1'b0}};
          word_d     = {WW{1'b0}};
          word_err_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = ST_FILL;
        cnt_d      = {CW{1'b0}};
        word_d     = {WW{1'b0}};
        word_err_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      cnt_q       <= {CW{1'b0}};
      word_q      <= {WW{1'b0}};
      word_err_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      word_err_q  <= word_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign seg_ready  = (state_q == ST_FILL);
  assign word_valid = (state_q == ST_FULL);
  assign word       = word_q;
  assign word_err   = word_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_seg7_hex_packer.sv
// Bench for seg7_hex_packer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a digit-queue model.
module tb_seg7_hex_packer;
  localparam int DIGITS = 4;
  localparam int W      = DIGITS * 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         seg_valid = 1'b0;
  logic [6:0]   seg = 7'h7F;
  logic         flush = 1'b0;
  logic         word_ready = 1'b0;
  logic         seg_ready;
  logic [W-1:0] word;
  logic         word_valid;
  logic         word_err;
  logic [7:0]   err_count;

  seg7_hex_packer #(.DIGITS(DIGITS), .data_width(4)) dut (
    .clk(clk), .reset(reset), .seg_valid(seg_valid), .seg(seg),
    .seg_ready(seg_ready), .flush(flush), .word(word), .word_valid(word_valid),
    .word_ready(word_ready), .word_err(word_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [6:0] codes [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int checks = 0;
  int errors = 0;

  // Model: digits accepted into the current word, word-complete flag, error state.
  bit m_full   = 1'b0;
  bit m_err    = 1'b0;
  int m_errcnt = 0;
  int m_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int ref_digit(input logic [6:0] s);
    int d = -1;
    for (int i = 0; i < 16; i++) if (codes[i] == s) d = i;
    return d;
  endfunction

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] r = '0;
    for (int k = 0; k < m_q.size(); k++) r = r + (W'(m_q[k]) << (4 * (DIGITS - 1 - k)));
    return r;
  endfunction

  function automatic void model_update();
    int d;
    if (!m_full) begin
      if (seg_valid) begin
        d = ref_digit(seg);
        if (d < 0) begin
          m_err = 1'b1;
          if (m_errcnt < 255) m_errcnt++;
          d = 0;
        end
        m_q.push_back(d);
      end
      if (m_q.size() == DIGITS || (flush && m_q.size() > 0)) m_full = 1'b1;
    end else if (word_ready) begin
      m_full = 1'b0;
      m_err  = 1'b0;
      m_q.delete();
    end
  endfunction

  function automatic logic [6:0] rand_code();
    if ($urandom_range(0, 9) < 7) return codes[$urandom_range(0, 15)];
    return 7'($urandom);
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("seg_ready", 32'(seg_ready), 32'(!m_full));
    check("word_valid", 32'(word_valid), 32'(m_full));
    check("err_count", 32'(err_count), 32'(m_errcnt));
    if (m_full || reset) begin
      check("word", 32'(word), 32'(model_word()));
      check("word_err", 32'(word_err), 32'(m_err));
    end
  end

  // Drive one cycle of inputs (called just after a falling edge).
  task automatic step(input bit v, input logic [6:0] s, input bit f, input bit r);
    seg_valid  = v;
    seg        = s;
    flush      = f;
    word_ready = r;
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    seg_valid  = 1'b0;
    flush      = 1'b0;
    m_full     = 1'b0;
    m_err      = 1'b0;
    m_errcnt   = 0;
    m_q.delete();
    #1;
    check("rst_seg_ready", 32'(seg_ready), 32'd1);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word", 32'(word), 32'd0);
    check("rst_word_err", 32'(word_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d, input bit r);
    step(1'b1, codes[a], 1'b0, r);
    step(1'b1, codes[b], 1'b0, r);
    step(1'b1, codes[c], 1'b0, r);
    step(1'b1, codes[d], 1'b0, r);
  endtask

  initial begin
    int n;
    bit acc;
    #1;
    do_reset();

    send4(1, 2, 3, 4, 1'b1);
    check("basic_word", 32'(word), 32'h1234);
    check("basic_valid", 32'(word_valid), 32'd1);
    check("basic_err", 32'(word_err), 32'd0);
    step(1'b0, 7'h7F, 1'b0, 1'b1);
    check("basic_done_valid", 32'(word_valid), 32'd0);
    check("basic_done_ready", 32'(seg_ready), 32'd1);

    send4(10, 11, 12, 13, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_word", 32'(word), 32'hABCD);
      check("bp_seg_ready", 32'(seg_ready), 32'd0);
      step(1'b1, codes[5], 1'b0, 1'b0);
    end
    step(1'b0, 7'h7F, 1'b0, 1'b1);
    check("bp_consumed", 32'(word_valid), 32'd0);
    step(1'b0, 7'h7F, 1'b0, 1'b1);
    check("bp_single_transfer", 32'(word_valid), 32'd0);

    step(1'b1, codes[10], 1'b0, 1'b1);
    step(1'b1, 7'h7F, 1'b0, 1'b1);
    step(1'b1, codes[12], 1'b0, 1'b1);
    step(1'b1, codes[13], 1'b0, 1'b1);
    check("ill_word", 32'(word), 32'hA0CD);
    check("ill_err", 32'(word_err), 32'd1);
    check("ill_count", 32'(err_count), 32'd1);
    step(1'b0, 7'h7F, 1'b0, 1'b1);
    send4(5, 6, 7, 9, 1'b1);
    check("ill_next_word", 32'(word), 32'h5679);
    check("ill_next_err", 32'(word_err), 32'd0);
    check("ill_next_count", 32'(err_count), 32'd1);
    step(1'b0, 7'h7F, 1'b0, 1'b1);

    step(1'b1, codes[14], 1'b0, 1'b1);
    step(1'b1, codes[15], 1'b0, 1'b1);
    step(1'b0, 7'h7F, 1'b1, 1'b1);
    check("flush_word", 32'(word), 32'hEF00);
    check("flush_valid", 32'(word_valid), 32'd1);
    step(1'b0, 7'h7F, 1'b0, 1'b1);
    step(1'b1, codes[1], 1'b0, 1'b1);
    step(1'b1, codes[2], 1'b0, 1'b1);
    step(1'b1, codes[8], 1'b1, 1'b1);
    check("flush_same_word", 32'(word), 32'h1280);
    step(1'b0, 7'h7F, 1'b0, 1'b1);
    step(1'b0, 7'h7F, 1'b1, 1'b1);
    check("flush_empty_valid", 32'(word_valid), 32'd0);
    check("flush_empty_ready", 32'(seg_ready), 32'd1);

    step(1'b1, codes[3], 1'b0, 1'b1);
    step(1'b1, codes[3], 1'b0, 1'b1);
    do_reset();
    send4(5, 6, 7, 9, 1'b1);
    check("rst_mid_word", 32'(word), 32'h5679);
    step(1'b0, 7'h7F, 1'b0, 1'b1);

    n = 0;
    while (n < 300) begin
      acc = !m_full;
      step(1'b1, 7'h7F, 1'b0, 1'b1);
      if (acc) n++;
    end
    check("sat_count", 32'(err_count), 32'd255);
    repeat (6) step(1'b1, 7'h7F, 1'b0, 1'b1);
    check("sat_hold", 32'(err_count), 32'd255);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), rand_code(),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
